even_count_checker: RTL and testbench

Receive-side monitor for the 4-bit even up/down counter. It samples the counter's state bus and direction input every clock and predicts the next even value. It flags any deviation and tracks wrap-around events. A persistent fault is latched for the test harness or system health logic. It sits on the observation side of the counter and drives nothing back into it.

---
 rtl/even_cnt_pkg.sv | 25 ++
 rtl/even_step.sv | 20 ++
 rtl/even_count_checker.sv | 124 ++++++++++++
 tb/tb_even_count_checker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/even_cnt_pkg.sv
// Shared constants, FSM encoding and the even-counter step function.
// Used by the checker RTL and by behavioural models of the counter.
package even_cnt_pkg;

    localparam int STATE_W = 4;
    localparam int STEP    = 2;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } chk_state_t;

    // Next legal counter value; arithmetic wraps modulo 2**STATE_W.
    function automatic logic [STATE_W-1:0] even_next(
        input logic [STATE_W-1:0] s,
        input logic               y,
        input logic               up_level
    );
        logic [STATE_W-1:0] step_v;
        step_v = STATE_W'(STEP);
        return (y == up_level) ? (s + step_v) : (s - step_v);
    endfunction

endpackage

// File: rtl/even_step.sv
// Combinational next-value predictor with wrap detection for one sample.
// Latency 0; no flow control.
module even_step
    import even_cnt_pkg::*;
#(
    parameter logic UP_LEVEL = 1'b0
) (
    input  logic [STATE_W-1:0] cur,
    input  logic               y,
    output logic [STATE_W-1:0] nxt,
    output logic               wrap
);

    always_comb begin
        nxt  = even_next(cur, y, UP_LEVEL);
        // A step that lands numerically on the wrong side of cur crossed the 14/0 boundary.
        wrap = (y == UP_LEVEL) ? (nxt < cur) : (nxt > cur);
    end

endmodule

// File: rtl/even_count_checker.sv
// Observation-side checker for the 4-bit even up/down counter: predicts, flags, latches faults.
// All outputs registered, one edge after the sample; check_en low freezes state and zeroes pulses.
module even_count_checker
    import even_cnt_pkg::*;
#(
    parameter logic UP_LEVEL = 1'b0,
    parameter int   MAX_MISS = 3,
    parameter int   ERR_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               check_en,
    input  logic [STATE_W-1:0] state_in,
    input  logic               y_in,
    output logic               locked,
    output logic               err_pulse,
    output logic               odd_pulse,
    output logic               wrap_pulse,
    output logic               fault,
    output logic [ERR_W-1:0]   err_count,
    output logic [STATE_W-1:0] expected
);

    localparam logic [2:0] MISS_LIMIT = 3'(MAX_MISS);

    chk_state_t         state_q, state_d;
    logic [2:0]         miss_q, miss_d, miss_inc;
    logic [STATE_W-1:0] expected_d;
    logic               pend_wrap_q, pend_wrap_d;
    logic               err_hit, odd_hit, wrap_hit;
    logic [STATE_W-1:0] step_nxt;
    logic               step_wrap;

    even_step #(
        .UP_LEVEL (UP_LEVEL)
    ) u_step (
        .cur  (state_in),
        .y    (y_in),
        .nxt  (step_nxt),
        .wrap (step_wrap)
    );

    always_comb begin
        state_d     = state_q;
        miss_d      = miss_q;
        expected_d  = expected;
        pend_wrap_d = pend_wrap_q;
        err_hit     = 1'b0;
        odd_hit     = state_in[0];
        wrap_hit    = 1'b0;
        miss_inc    = miss_q + 3'd1;

        case (state_q)
            SYNC: begin
                if (state_in[0]) begin
                    err_hit = 1'b1;
                end else begin
                    expected_d  = step_nxt;
                    pend_wrap_d = step_wrap;
                    state_d     = TRACK;
                end
            end
            TRACK: begin
                if (state_in == expected) begin
                    // The wrap belongs to the step that produced this sample, recorded at prediction time.
                    wrap_hit    = pend_wrap_q;
                    expected_d  = step_nxt;
                    pend_wrap_d = step_wrap;
                    miss_d      = 3'd0;
                end else begin
                    err_hit = 1'b1;
                    miss_d  = miss_inc;
                    if (miss_inc >= MISS_LIMIT) begin
                        state_d = FAULT;
                    end else if (state_in[0]) begin
                        state_d = SYNC;
                    end else begin
                        expected_d  = step_nxt;
                        pend_wrap_d = step_wrap;
                    end
                end
            end
            FAULT: begin
                err_hit = (state_in != expected);
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= SYNC;
            miss_q      <= 3'd0;
            pend_wrap_q <= 1'b0;
            expected    <= '0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            err_pulse   <= 1'b0;
            odd_pulse   <= 1'b0;
            wrap_pulse  <= 1'b0;
            err_count   <= '0;
        end else if (check_en) begin
            state_q     <= state_d;
            miss_q      <= miss_d;
            pend_wrap_q <= pend_wrap_d;
            expected    <= expected_d;
            locked      <= (state_d == TRACK);
            fault       <= (state_d == FAULT);
            err_pulse   <= err_hit;
            odd_pulse   <= odd_hit;
            wrap_pulse  <= wrap_hit;
            if (err_hit && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end else begin
            err_pulse  <= 1'b0;
            odd_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_even_count_checker.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_even_count_checker;

    localparam logic UP = 1'b0;
    localparam logic DN = 1'b1;
    localparam int   MAX_MISS = 3;

    localparam int M_SYNC  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    logic       clock = 1'b0;
    logic       reset, check_en, y_in;
    logic [3:0] state_in;

    logic       locked, err_pulse, odd_pulse, wrap_pulse, fault;
    logic [7:0] err_count;
    logic [3:0] expected;

    logic       locked_b, err_pulse_b, odd_pulse_b, wrap_pulse_b, fault_b;
    logic [1:0] err_count_b;
    logic [3:0] expected_b;

    always #5 clock = ~clock;

    even_count_checker #(.UP_LEVEL(UP), .MAX_MISS(MAX_MISS), .ERR_W(8)) dut (
        .clock(clock), .reset(reset), .check_en(check_en), .state_in(state_in), .y_in(y_in),
        .locked(locked), .err_pulse(err_pulse), .odd_pulse(odd_pulse), .wrap_pulse(wrap_pulse),
        .fault(fault), .err_count(err_count), .expected(expected)
    );

    even_count_checker #(.UP_LEVEL(UP), .MAX_MISS(MAX_MISS), .ERR_W(2)) dut_narrow (
        .clock(clock), .reset(reset), .check_en(check_en), .state_in(state_in), .y_in(y_in),
        .locked(locked_b), .err_pulse(err_pulse_b), .odd_pulse(odd_pulse_b), .wrap_pulse(wrap_pulse_b),
        .fault(fault_b), .err_count(err_count_b), .expected(expected_b)
    );

    typedef struct {
        logic locked, err, odd, wrap, fault;
        int   errs;
        int   exp_v;
    } resp_t;

    resp_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model state
    int m_mode, m_exp, m_miss, m_errs;
    bit m_wexp;

    function automatic int nx(input int s, input logic y);
        return (y == UP) ? (s + 2) % 16 : (s + 14) % 16;
    endfunction

    function automatic bit crosses(input int s, input logic y);
        return (y == UP) ? (s == 14) : (s == 0);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input logic rst, input logic en, input int s, input logic y);
        resp_t r;
        @(negedge clock);
        reset    = rst;
        check_en = en;
        state_in = 4'(s);
        y_in     = y;
        r.err = 1'b0; r.odd = 1'b0; r.wrap = 1'b0;
        if (!rst) begin
            m_mode = M_SYNC; m_exp = 0; m_wexp = 0; m_miss = 0; m_errs = 0;
        end else if (en) begin
            r.odd = (s % 2) == 1;
            if (m_mode == M_SYNC) begin
                if (r.odd) r.err = 1'b1;
                else begin m_exp = nx(s, y); m_wexp = crosses(s, y); m_mode = M_TRACK; end
            end else if (m_mode == M_TRACK) begin
                if (s == m_exp) begin
                    r.wrap = m_wexp; m_exp = nx(s, y); m_wexp = crosses(s, y); m_miss = 0;
                end else begin
                    r.err = 1'b1;
                    m_miss++;
                    if (m_miss >= MAX_MISS) m_mode = M_FAULT;
                    else if (r.odd) m_mode = M_SYNC;
                    else begin m_exp = nx(s, y); m_wexp = crosses(s, y); end
                end
            end else begin
                r.err = (s != m_exp);
            end
            if (r.err) m_errs++;
        end
        r.locked = (m_mode == M_TRACK);
        r.fault  = (m_mode == M_FAULT);
        r.errs   = m_errs;
        r.exp_v  = m_exp;
        sb_q.push_back(r);
    endtask

    always @(posedge clock) begin
        resp_t r;
        #1;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk("locked",      int'(locked),      int'(r.locked));
            chk("err_pulse",   int'(err_pulse),   int'(r.err));
            chk("odd_pulse",   int'(odd_pulse),   int'(r.odd));
            chk("wrap_pulse",  int'(wrap_pulse),  int'(r.wrap));
            chk("fault",       int'(fault),       int'(r.fault));
            chk("expected",    int'(expected),    r.exp_v);
            chk("err_count",   int'(err_count),   (r.errs > 255) ? 255 : r.errs);
            chk("err_count_w2", int'(err_count_b), (r.errs > 3) ? 3 : r.errs);
            chk("fault_w2",    int'(fault_b),     int'(r.fault));
        end
    end

    initial begin
        int cur;
        logic y;
        reset = 1'b0; check_en = 1'b1; state_in = '0; y_in = UP;

        // Up-count through the full range including the 14->0 wrap
        step(0, 1, 0, UP);
        for (int v = 0; v <= 14; v += 2) step(1, 1, v, UP);
        step(1, 1, 0, UP);

        // Direction flip mid-stream with a down wrap
        step(0, 1, 0, UP);
        step(1, 1, 6, UP); step(1, 1, 8, DN);
        step(1, 1, 6, DN); step(1, 1, 4, DN); step(1, 1, 2, DN);
        step(1, 1, 0, DN); step(1, 1, 14, DN);

        // Single even mismatch followed by resync
        step(0, 1, 0, UP);
        step(1, 1, 0, UP); step(1, 1, 2, UP); step(1, 1, 4, UP);
        step(1, 1, 10, UP); step(1, 1, 12, UP); step(1, 1, 14, UP);

        // Odd injection drops lock, next even relocks
        step(0, 1, 0, UP);
        step(1, 1, 0, UP); step(1, 1, 2, UP); step(1, 1, 5, UP);
        step(1, 1, 8, UP); step(1, 1, 10, UP);

        // Three consecutive misses latch FAULT; reset clears it
        step(0, 1, 0, UP);
        step(1, 1, 0, UP); step(1, 1, 2, UP);
        step(1, 1, 8, UP); step(1, 1, 4, UP); step(1, 1, 12, UP);
        step(1, 1, 6, UP); step(1, 1, 8, UP); step(1, 1, 9, UP);
        step(0, 1, 0, UP);
        step(1, 1, 3, UP);

        // Saturation of the narrow counter
        step(0, 1, 0, UP);
        for (int v = 1; v <= 9; v += 2) step(1, 1, v, UP);

        // check_en low masks an odd value
        step(0, 1, 0, UP);
        step(1, 1, 0, UP); step(1, 1, 2, UP);
        step(1, 0, 7, UP); step(1, 0, 7, DN);
        step(1, 1, 4, UP);

        // Randomized mix of legal counting, direction flips, corruptions and gating
        step(0, 1, 0, UP);
        cur = 0; y = UP;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                step(0, 1, 0, UP);
                cur = 0;
            end else begin
                if ($urandom_range(0, 99) < 20) y = ~y;
                if ($urandom_range(0, 99) < 10) cur = $urandom_range(0, 15);
                step(1, ($urandom_range(0, 99) >= 10), cur, y);
                cur = nx(cur, y);
            end
        end

        @(posedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
